// File: rtl/nec_bus_ctrl.sv
// NEC V30/V33 external-bus controller: programmable NEC_CLK, stretched NEC_RESET,
// bus-cycle decode to a req/ack transaction and READY wait-state generation.
// Optional bus trace outputs are enabled by defining NEC_BUS_TRACE_EN.
module nec_bus_ctrl #(
    parameter int DIV_W        = 4,
    parameter int WAIT_W       = 4,
    parameter int RESET_CYCLES = 16
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic [DIV_W-1:0]  div_sel,
    input  logic [WAIT_W-1:0] wait_states,
    output logic              nec_clk,
    output logic              nec_reset,
    output logic              nec_ready,
    input  logic [19:0]       nec_ad_in,
    output logic [15:0]       nec_ad_out,
    output logic              nec_ad_oe,
    input  logic              nec_astb,
    input  logic              nec_rdn,
    input  logic              nec_wrn,
    input  logic              nec_ion,
    input  logic              nec_uben,
    output logic              mem_req,
    output logic              mem_we,
    output logic              mem_io,
    output logic [19:0]       mem_addr,
    output logic [1:0]        mem_be,
    output logic [15:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [15:0]       mem_rdata
`ifdef NEC_BUS_TRACE_EN
    ,
    output logic              trace_valid,
    output logic              trace_we,
    output logic              trace_io,
    output logic [19:0]       trace_addr,
    output logic [15:0]       trace_data,
    output logic [15:0]       trace_cyc
`endif
);

    localparam int RST_W = $clog2(RESET_CYCLES + 1);
    localparam logic [24:0] SYNC_IDLE = {20'h0, 5'b11111};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t            state;
    logic [DIV_W-1:0]  div_cnt;
    logic [DIV_W-1:0]  div_cur;
    logic              div_loaded;
    logic [DIV_W-1:0]  div_eff;
    logic              half_tick;
    logic              rise_tick;
    logic [RST_W-1:0]  rst_cnt;
    logic [24:0]       sync1;
    logic [24:0]       sync2;
    logic              astb_q;
    logic              rdn_q;
    logic              wrn_q;
    logic [19:0]       ad_s;
    logic              astb_s;
    logic              rdn_s;
    logic              wrn_s;
    logic              ion_s;
    logic              uben_s;
    logic              astb_fall;
    logic              rdn_fall;
    logic              wrn_fall;
    logic              rdn_rise;
    logic              wrn_rise;
    logic              strobe_rise;
    logic              aborted;
    logic [WAIT_W-1:0] wait_tgt;
    logic [WAIT_W-1:0] wait_cnt;

    // Until the first rising toggle there is no sampled divider, so use div_sel live.
    assign div_eff   = div_loaded ? div_cur : div_sel;
    assign half_tick = (div_cnt == div_eff);
    assign rise_tick = half_tick & ~nec_clk;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            div_cnt    <= '0;
            div_cur    <= '0;
            div_loaded <= 1'b0;
            nec_clk    <= 1'b0;
        end else if (half_tick) begin
            div_cnt <= '0;
            nec_clk <= ~nec_clk;
            if (!nec_clk) begin
                div_cur    <= div_sel;
                div_loaded <= 1'b1;
            end
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            rst_cnt   <= '0;
            nec_reset <= 1'b1;
        end else if (nec_reset && rise_tick) begin
            rst_cnt <= rst_cnt + 1'b1;
            if (rst_cnt == RST_W'(RESET_CYCLES - 1)) begin
                nec_reset <= 1'b0;
            end
        end
    end

    // Strobes idle high so that reset never produces a spurious falling edge.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            sync1  <= SYNC_IDLE;
            sync2  <= SYNC_IDLE;
            astb_q <= 1'b1;
            rdn_q  <= 1'b1;
            wrn_q  <= 1'b1;
        end else begin
            sync1  <= {nec_ad_in, nec_astb, nec_rdn, nec_wrn, nec_ion, nec_uben};
            sync2  <= sync1;
            astb_q <= astb_s;
            rdn_q  <= rdn_s;
            wrn_q  <= wrn_s;
        end
    end

    assign ad_s        = sync2[24:5];
    assign astb_s      = sync2[4];
    assign rdn_s       = sync2[3];
    assign wrn_s       = sync2[2];
    assign ion_s       = sync2[1];
    assign uben_s      = sync2[0];
    assign astb_fall   = astb_q & ~astb_s;
    assign rdn_fall    = rdn_q & ~rdn_s;
    assign wrn_fall    = wrn_q & ~wrn_s;
    assign rdn_rise    = ~rdn_q & rdn_s;
    assign wrn_rise    = ~wrn_q & wrn_s;
    assign strobe_rise = mem_we ? wrn_rise : rdn_rise;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            nec_ready  <= 1'b1;
            nec_ad_out <= '0;
            nec_ad_oe  <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_io     <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= '0;
            mem_wdata  <= '0;
            aborted    <= 1'b0;
            wait_tgt   <= '0;
            wait_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (astb_fall) begin
                        mem_addr <= ad_s;
                        mem_io   <= ~ion_s;
                        mem_be   <= {~uben_s, ~ad_s[0]};
                    end
                    // A low RDn wins, so both strobes low is a read.
                    if (rdn_fall || wrn_fall) begin
                        state     <= ST_REQ;
                        mem_req   <= 1'b1;
                        nec_ready <= 1'b0;
                        aborted   <= 1'b0;
                        mem_we    <= rdn_s;
                        if (rdn_s) begin
                            mem_wdata <= ad_s[15:0];
                        end
                    end
                end
                ST_REQ: begin
                    if (strobe_rise) begin
                        aborted   <= 1'b1;
                        nec_ready <= 1'b1;
                    end
                    if (mem_ack) begin
                        mem_req  <= 1'b0;
                        wait_tgt <= wait_states;
                        wait_cnt <= '0;
                        if (aborted || strobe_rise) begin
                            state     <= ST_IDLE;
                            nec_ready <= 1'b1;
                        end else begin
                            if (!mem_we) begin
                                nec_ad_out <= mem_rdata;
                            end
                            if (wait_states != '0) begin
                                state <= ST_WAIT;
                            end else begin
                                state     <= ST_DONE;
                                nec_ready <= 1'b1;
                                nec_ad_oe <= ~mem_we;
                            end
                        end
                    end
                end
                ST_WAIT: begin
                    if (strobe_rise) begin
                        state     <= ST_IDLE;
                        nec_ready <= 1'b1;
                    end else if (rise_tick) begin
                        if (wait_cnt == wait_tgt - 1'b1) begin
                            state     <= ST_DONE;
                            nec_ready <= 1'b1;
                            nec_ad_oe <= ~mem_we;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (strobe_rise) begin
                        state     <= ST_IDLE;
                        nec_ad_oe <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef NEC_BUS_TRACE_EN
    logic was_done;

    // The pulse trails DONE entry by one cycle so the read data is already in nec_ad_out.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            was_done    <= 1'b0;
            trace_valid <= 1'b0;
            trace_we    <= 1'b0;
            trace_io    <= 1'b0;
            trace_addr  <= '0;
            trace_data  <= '0;
            trace_cyc   <= '0;
        end else begin
            was_done    <= (state == ST_DONE);
            trace_valid <= (state == ST_DONE) && !was_done;
            trace_we    <= mem_we;
            trace_io    <= mem_io;
            trace_addr  <= mem_addr;
            trace_data  <= mem_we ? mem_wdata : nec_ad_out;
            if (rise_tick) begin
                trace_cyc <= trace_cyc + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_nec_bus_ctrl.sv
// Directed self-checking bench for nec_bus_ctrl: divider, reset stretch, read/write,
// abort and mid-cycle reset; trace pulses are checked when NEC_BUS_TRACE_EN is defined.
module tb_nec_bus_ctrl;

    logic        clk_sys;
    logic        reset;
    logic [3:0]  div_sel;
    logic [3:0]  wait_states;
    logic        nec_clk;
    logic        nec_reset;
    logic        nec_ready;
    logic [19:0] nec_ad_in;
    logic [15:0] nec_ad_out;
    logic        nec_ad_oe;
    logic        nec_astb;
    logic        nec_rdn;
    logic        nec_wrn;
    logic        nec_ion;
    logic        nec_uben;
    logic        mem_req;
    logic        mem_we;
    logic        mem_io;
    logic [19:0] mem_addr;
    logic [1:0]  mem_be;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;

    int checks = 0;
    int errors = 0;

`ifdef NEC_BUS_TRACE_EN
    logic        trace_valid;
    logic        trace_we;
    logic        trace_io;
    logic [19:0] trace_addr;
    logic [15:0] trace_data;
    logic [15:0] trace_cyc;
    int          tr_n = 0;
    logic [19:0] tr_addr [2];
    logic [15:0] tr_data [2];
    logic        tr_we   [2];

    // Keep the last two trace records.
    always @(negedge clk_sys) begin
        if (trace_valid) begin
            tr_addr[0] = tr_addr[1];
            tr_data[0] = tr_data[1];
            tr_we[0]   = tr_we[1];
            tr_addr[1] = trace_addr;
            tr_data[1] = trace_data;
            tr_we[1]   = trace_we;
            tr_n       = tr_n + 1;
        end
    end
`endif

    nec_bus_ctrl dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .div_sel     (div_sel),
        .wait_states (wait_states),
        .nec_clk     (nec_clk),
        .nec_reset   (nec_reset),
        .nec_ready   (nec_ready),
        .nec_ad_in   (nec_ad_in),
        .nec_ad_out  (nec_ad_out),
        .nec_ad_oe   (nec_ad_oe),
        .nec_astb    (nec_astb),
        .nec_rdn     (nec_rdn),
        .nec_wrn     (nec_wrn),
        .nec_ion     (nec_ion),
        .nec_uben    (nec_uben),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_io      (mem_io),
        .mem_addr    (mem_addr),
        .mem_be      (mem_be),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata)
`ifdef NEC_BUS_TRACE_EN
        ,
        .trace_valid (trace_valid),
        .trace_we    (trace_we),
        .trace_io    (trace_io),
        .trace_addr  (trace_addr),
        .trace_data  (trace_data),
        .trace_cyc   (trace_cyc)
`endif
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    task automatic tick(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Counts clk_sys cycles until the next observed nec_clk rise; 999 on timeout.
    task automatic wait_rise(output int cyc);
        logic prev;
        logic seen;
        prev = nec_clk;
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < 100) begin
            @(negedge clk_sys);
            cyc++;
            seen = nec_clk && !prev;
            prev = nec_clk;
        end
        if (!seen) cyc = 999;
    endtask

    task automatic wait_for_req(input string tag);
        int n;
        n = 0;
        while (!mem_req && n < 50) begin
            @(negedge clk_sys);
            n++;
        end
        check_output(tag, 32'(mem_req), 32'd1);
    endtask

    task automatic apply_stimulus(input logic [19:0] addr, input logic uben);
        nec_ad_in = addr;
        nec_uben  = uben;
        tick(1);
        nec_astb = 1'b0;
        tick(4);
    endtask

`ifdef NEC_BUS_TRACE_EN
    task automatic run_cycle(input logic we, input logic [19:0] addr, input logic [15:0] data);
        apply_stimulus(addr, 1'b0);
        nec_astb = 1'b1;
        if (we) begin
            nec_ad_in = {4'h0, data};
            nec_wrn   = 1'b0;
        end else begin
            nec_rdn = 1'b0;
        end
        wait_for_req("trace_req");
        mem_rdata = data;
        mem_ack   = 1'b1;
        tick(1);
        mem_ack = 1'b0;
        tick(2);
        nec_rdn = 1'b1;
        nec_wrn = 1'b1;
        tick(4);
    endtask
`endif

    initial begin
        int c;
        int rises;
        int n;
        logic prev;
        logic oe_seen;

        reset       = 1'b1;
        div_sel     = 4'd3;
        wait_states = 4'd0;
        nec_ad_in   = '0;
        nec_astb    = 1'b1;
        nec_rdn     = 1'b1;
        nec_wrn     = 1'b1;
        nec_ion     = 1'b1;
        nec_uben    = 1'b1;
        mem_ack     = 1'b0;
        mem_rdata   = '0;
        tick(3);

        check_output("rst_nec_clk", 32'(nec_clk), 32'd0);
        check_output("rst_nec_reset", 32'(nec_reset), 32'd1);
        check_output("rst_ready", 32'(nec_ready), 32'd1);
        check_output("rst_oe", 32'(nec_ad_oe), 32'd0);
        check_output("rst_ad_out", 32'(nec_ad_out), 32'd0);
        check_output("rst_req", 32'(mem_req), 32'd0);
        check_output("rst_addr", 32'(mem_addr), 32'd0);
        check_output("rst_be", 32'(mem_be), 32'd0);

        // Reset stretch: count nec_clk rises until nec_reset drops.
        reset = 1'b0;
        rises = 0;
        n     = 0;
        prev  = nec_clk;
        while (nec_reset && n < 400) begin
            @(negedge clk_sys);
            n++;
            if (nec_clk && !prev) rises++;
            prev = nec_clk;
        end
        check_output("reset_stretch", 32'(rises), 32'd16);
        check_output("reset_low", 32'(nec_reset), 32'd0);

        // Divider: period 8 at div_sel=3, change mid-period, then period 4.
        wait_rise(c);
        check_output("div3_period", 32'(c), 32'd8);
        tick(2);
        div_sel = 4'd1;
        wait_rise(c);
        check_output("div_switch_rest", 32'(c), 32'd6);
        wait_rise(c);
        check_output("div1_period", 32'(c), 32'd4);

        // Read with two wait states.
        wait_states = 4'd2;
        apply_stimulus(20'h12346, 1'b0);
        check_output("rd_addr", 32'(mem_addr), 32'h12346);
        check_output("rd_io", 32'(mem_io), 32'd0);
        check_output("rd_be", 32'(mem_be), 32'd3);
        nec_astb = 1'b1;
        nec_rdn  = 1'b0;
        wait_for_req("rd_req");
        check_output("rd_we", 32'(mem_we), 32'd0);
        check_output("rd_ready_req", 32'(nec_ready), 32'd0);
        tick(2);
        mem_rdata = 16'hBEEF;
        mem_ack   = 1'b1;
        tick(1);
        mem_ack   = 1'b0;
        mem_rdata = 16'h0000;
        check_output("rd_req_drop", 32'(mem_req), 32'd0);
        check_output("rd_ready_ack", 32'(nec_ready), 32'd0);
        check_output("rd_oe_ack", 32'(nec_ad_oe), 32'd0);
        wait_rise(c);
        check_output("rd_ready_wait1", 32'(nec_ready), 32'd0);
        wait_rise(c);
        check_output("rd_ready_done", 32'(nec_ready), 32'd1);
        check_output("rd_oe_done", 32'(nec_ad_oe), 32'd1);
        check_output("rd_ad_out", 32'(nec_ad_out), 32'hBEEF);
        tick(3);
        check_output("rd_oe_hold", 32'(nec_ad_oe), 32'd1);
        nec_rdn = 1'b1;
        tick(4);
        check_output("rd_oe_release", 32'(nec_ad_oe), 32'd0);

        // Write, no wait states, ack on the first REQ cycle.
        wait_states = 4'd0;
        apply_stimulus(20'h00101, 1'b1);
        check_output("wr_addr", 32'(mem_addr), 32'h00101);
        check_output("wr_be", 32'(mem_be), 32'd0);
        nec_astb  = 1'b1;
        nec_ad_in = 20'h000A5;
        nec_wrn   = 1'b0;
        wait_for_req("wr_req");
        check_output("wr_we", 32'(mem_we), 32'd1);
        check_output("wr_wdata", 32'(mem_wdata), 32'h00A5);
        check_output("wr_ready_req", 32'(nec_ready), 32'd0);
        mem_ack = 1'b1;
        tick(1);
        mem_ack = 1'b0;
        check_output("wr_req_drop", 32'(mem_req), 32'd0);
        check_output("wr_ready_done", 32'(nec_ready), 32'd1);
        check_output("wr_oe", 32'(nec_ad_oe), 32'd0);
        nec_wrn = 1'b1;
        tick(4);

        // Abort: RDn rises during WAIT.
        wait_states = 4'd3;
        apply_stimulus(20'h00200, 1'b0);
        nec_astb = 1'b1;
        nec_rdn  = 1'b0;
        wait_for_req("ab_req");
        mem_rdata = 16'h1234;
        mem_ack   = 1'b1;
        tick(1);
        mem_ack = 1'b0;
        tick(1);
        nec_rdn = 1'b1;
        oe_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            oe_seen = oe_seen | nec_ad_oe;
        end
        check_output("ab_ready", 32'(nec_ready), 32'd1);
        check_output("ab_oe_never", 32'(oe_seen), 32'd0);

        // Reset asserted during REQ of the next cycle.
        apply_stimulus(20'h00300, 1'b0);
        nec_astb = 1'b1;
        nec_rdn  = 1'b0;
        wait_for_req("rr_req_idle_ok");
        reset = 1'b1;
        #1;
        check_output("rr_req_drop", 32'(mem_req), 32'd0);
        check_output("rr_ready", 32'(nec_ready), 32'd1);
        check_output("rr_addr", 32'(mem_addr), 32'd0);
        check_output("rr_nec_reset", 32'(nec_reset), 32'd1);
        nec_rdn = 1'b1;
        tick(2);
        reset   = 1'b0;
        mem_ack = 1'b1;
        tick(1);
        mem_ack = 1'b0;
        tick(4);
        check_output("rr_late_ack_req", 32'(mem_req), 32'd0);
        check_output("rr_late_ack_oe", 32'(nec_ad_oe), 32'd0);
        check_output("rr_late_ack_ready", 32'(nec_ready), 32'd1);

`ifdef NEC_BUS_TRACE_EN
        begin
            int base;
            wait_states = 4'd0;
            base = tr_n;
            run_cycle(1'b1, 20'h00400, 16'h1111);
            run_cycle(1'b0, 20'h00402, 16'h2222);
            check_output("tr_count", 32'(tr_n - base), 32'd2);
            check_output("tr0_addr", 32'(tr_addr[0]), 32'h00400);
            check_output("tr0_data", 32'(tr_data[0]), 32'h1111);
            check_output("tr0_we", 32'(tr_we[0]), 32'd1);
            check_output("tr1_addr", 32'(tr_addr[1]), 32'h00402);
            check_output("tr1_data", 32'(tr_data[1]), 32'h2222);
            check_output("tr1_we", 32'(tr_we[1]), 32'd0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
